// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Shares a single memory bus master port between the CPU instruction-fetch
//   port and the CPU data port. One bus transaction is in flight at a time.
//   Each completed result is held until the pipeline advances, so an access is
//   never issued twice.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a bus cycle that sees no
//   m_ack within TIMEOUT_CYCLES cycles. The aborted access returns 32'h0 and
//   bus_err pulses for one cycle. Without the macro bus_err is constant 0.
//
// Handshake: a CPU port holds x_req (and its address/data) for as long as
//   x_stall is high. The cycle x_req & ~x_stall is the one in which x_rdata
//   is valid. On the bus side m_req and all m_* fields stay constant until
//   the cycle in which m_ack is high, and m_rdata is taken in that cycle.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   i_req, i_addr                instruction fetch request and address
//   i_rdata, i_stall             fetched word, fetch stall
//   d_req, d_we, d_mask          data request, write enable, byte lanes
//   d_addr, d_wdata              data address, write data
//   d_rdata, d_stall             load data, data stall
//   m_req, m_we, m_mask          bus request, write enable, byte lanes
//   m_addr, m_wdata              bus address, write data
//   m_ack, m_rdata               bus completion and read data (same cycle)
//   bus_err                      one-cycle pulse on a timeout abort
module cpu_mem_arbiter #(
  parameter int I_STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_mask,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  localparam int SW = $clog2(I_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(I_STARVE_LIMIT);

  state_t        state_q, state_d;
  logic          done_i_q, done_i_d;
  logic          done_d_q, done_d_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [3:0]    m_mask_q, m_mask_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          pending_i, pending_d, advance, complete;
  logic [31:0]   result;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          bus_err_q, bus_err_d;
`endif

  // A port is pending while it requests and has no held result; that is
  // exactly its stall. The pipeline advances when neither port is stalled.
  assign pending_i = i_req & ~done_i_q;
  assign pending_d = d_req & ~done_d_q;
  assign i_stall   = pending_i;
  assign d_stall   = pending_d;
  assign advance   = ~pending_i & ~pending_d;

  always_comb begin
    state_d      = state_q;
    done_i_d     = done_i_q;
    done_d_d     = done_d_q;
    starve_cnt_d = starve_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_mask_d     = m_mask_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    complete     = 1'b0;
    result       = m_rdata;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    bus_err_d    = 1'b0;
`endif

    // Results are consumed on advance. A completion on the same edge still
    // sets its done flag (only possible when that port dropped its request),
    // and that stale result is dropped at the following advance.
    if (advance) begin
      done_i_d = 1'b0;
      done_d_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Data wins ties until it has starved the fetch port for the limit.
        if (pending_d && (!pending_i || starve_cnt_q < STARVE_MAX)) begin
          state_d   = GNT_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_mask_d  = d_mask;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (pending_i) starve_cnt_d = starve_cnt_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else if (pending_i) begin
          state_d      = GNT_I;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_mask_d     = 4'hF;
          m_addr_d     = i_addr;
          m_wdata_d    = 32'h0;
          starve_cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      GNT_I, GNT_D: begin
        if (m_ack) begin
          complete = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          complete  = 1'b1;
          result    = 32'h0;
          bus_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
        if (complete) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == GNT_I) begin
            i_rdata_d = result;
            done_i_d  = 1'b1;
          end else begin
            d_rdata_d = result;
            done_d_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      done_i_q     <= 1'b0;
      done_d_q     <= 1'b0;
      starve_cnt_q <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_mask_q     <= 4'h0;
      m_addr_q     <= 32'h0;
      m_wdata_q    <= 32'h0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      done_i_q     <= done_i_d;
      done_d_q     <= done_d_d;
      starve_cnt_q <= starve_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_mask_q     <= m_mask_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_mask  = m_mask_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule
